// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX -> MEM pipeline register with optional signed-overflow trap.
//
// Captures the EX-stage result, store data, destination register and control
// bits on every rising clk. Priority at each edge is flush > stall > load.
// flush clears the control bits and leaves the data fields alone. stall
// freezes every mem_* register.
//
// Optional feature, macro EX_MEM_OVF_TRAP_EN:
//   defined   - a signed add/sub that overflows while loading is captured.
//               The slot loads with all control bits cleared, exc_epc gets
//               its PC, and the block enters TRAP. In TRAP, exc_req and
//               trap_busy are high and every load is squashed. exc_ack
//               returns the block to RUN, even when stall is also high.
//   undefined - no FSM. exc_req, trap_busy and exc_epc are tied to 0, and an
//               overflowing instruction loads like any other.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   stall, flush        hold / squash this stage
//   ex_valid, ex_pc     EX slot holds a real instruction, and its address
//   alu_result/zero/overflow, ex_rt_data, ex_rd   EX datapath
//   ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_ovf_chk
//                       EX control bits
//   exc_ack             trap acknowledge
//   mem_*               registered MEM-stage copies
//   exc_req, exc_epc, trap_busy   trap request, faulting PC, FSM in TRAP
module ex_mem_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic [31:0] ex_rt_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_branch,
    input  logic        ex_ovf_chk,
    input  logic        exc_ack,
    output logic        mem_valid,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_rt_data,
    output logic [4:0]  mem_rd,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic        mem_branch_taken,
    output logic        exc_req,
    output logic [31:0] exc_epc,
    output logic        trap_busy
);

    logic load;
    logic squash;   // slot loads, but with every control bit forced to 0
    logic slot_ok;  // slot carries side effects

    assign load = ~flush & ~stall;

`ifdef EX_MEM_OVF_TRAP_EN
    typedef enum logic {RUN, TRAP} state_t;

    state_t state, state_nxt;
    logic   fault;

    // A fault only exists on a real load. A flushed or stalled edge captures nothing.
    assign fault  = load & ex_valid & ex_ovf_chk & alu_overflow;
    assign squash = (state == TRAP) | fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            exc_epc <= '0;
        end else begin
            state <= state_nxt;
            // Only the first fault is recorded. exc_epc holds while in TRAP.
            if (state == RUN && fault)
                exc_epc <= ex_pc;
        end
    end

    // exc_ack is checked regardless of stall, so a stalled pipe can still leave TRAP.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (fault)   state_nxt = TRAP;
            TRAP:    if (exc_ack) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    assign exc_req   = (state == TRAP);
    assign trap_busy = (state == TRAP);
`else
    logic unused_trap_inputs;

    assign squash             = 1'b0;
    assign exc_req            = 1'b0;
    assign trap_busy          = 1'b0;
    assign exc_epc            = '0;
    assign unused_trap_inputs = ^{alu_overflow, ex_ovf_chk, exc_ack, ex_pc};
`endif

    assign slot_ok = ex_valid & ~squash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid        <= 1'b0;
            mem_alu_result   <= '0;
            mem_rt_data      <= '0;
            mem_rd           <= '0;
            mem_reg_write    <= 1'b0;
            mem_mem_read     <= 1'b0;
            mem_mem_write    <= 1'b0;
            mem_branch_taken <= 1'b0;
        end else if (flush) begin
            // Data fields hold. Only the bits with side effects are cleared.
            mem_valid        <= 1'b0;
            mem_reg_write    <= 1'b0;
            mem_mem_read     <= 1'b0;
            mem_mem_write    <= 1'b0;
            mem_branch_taken <= 1'b0;
        end else if (load) begin
            mem_alu_result   <= alu_result;
            mem_rt_data      <= ex_rt_data;
            mem_rd           <= ex_rd;
            mem_valid        <= slot_ok;
            mem_reg_write    <= slot_ok & ex_reg_write;
            mem_mem_read     <= slot_ok & ex_mem_read;
            mem_mem_write    <= slot_ok & ex_mem_write;
            mem_branch_taken <= slot_ok & ex_branch & alu_zero;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg. A table of {inputs, expected outputs} vectors is applied one per
// clock. The expected bundle is pushed to a queue when a vector is driven, and it is popped
// and compared just after the capturing edge. A hand-written sequence covers the async
// reset case. Expectations follow EX_MEM_OVF_TRAP_EN when the macro is defined.
module tb_ex_mem_reg;

`ifdef EX_MEM_OVF_TRAP_EN
    localparam bit T = 1'b1;
`else
    localparam bit T = 1'b0;
`endif
    localparam logic [31:0] EPC = T ? 32'h0040_0010 : 32'h0;

    typedef struct packed {
        logic        stall, flush, v;
        logic [31:0] pc, alu;
        logic        zero, ovf, chk;
        logic [31:0] rt;
        logic [4:0]  rd;
        logic        rw, mr, mw, br, ack;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] alu, rt;
        logic [4:0]  rd;
        logic        rw, mr, mw, bt, exc, busy;
        logic [31:0] epc;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    logic clk = 1'b0, rst_n;
    logic stall, flush, ex_valid, alu_zero, alu_overflow;
    logic [31:0] ex_pc, alu_result, ex_rt_data;
    logic [4:0]  ex_rd;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_ovf_chk, exc_ack;
    logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_branch_taken;
    logic [31:0] mem_alu_result, mem_rt_data, exc_epc;
    logic [4:0]  mem_rd;
    logic exc_req, trap_busy;

    int checks = 0, failures = 0;
    exp_t sb[$];
    vec_t tbl[$];

    ex_mem_reg dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .ex_rt_data(ex_rt_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_ovf_chk(ex_ovf_chk),
        .exc_ack(exc_ack), .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
        .mem_rt_data(mem_rt_data), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_branch_taken(mem_branch_taken), .exc_req(exc_req), .exc_epc(exc_epc),
        .trap_busy(trap_busy)
    );

    always #5 clk = ~clk;

    function automatic in_t iv(logic s, logic f, logic v, logic [31:0] pc, logic [31:0] alu,
                               logic z, logic o, logic c, logic [31:0] rt, logic [4:0] rd,
                               logic rw, logic mr, logic mw, logic br, logic ack);
        in_t x;
        x = '{s, f, v, pc, alu, z, o, c, rt, rd, rw, mr, mw, br, ack};
        return x;
    endfunction

    function automatic exp_t e(logic v, logic [31:0] alu, logic [31:0] rt, logic [4:0] rd,
                               logic rw, logic mr, logic mw, logic bt, logic exc,
                               logic [31:0] epc);
        exp_t x;
        x = '{v, alu, rt, rd, rw, mr, mw, bt, exc, exc, epc};
        return x;
    endfunction

    function automatic exp_t actual();
        exp_t x;
        x = '{mem_valid, mem_alu_result, mem_rt_data, mem_rd, mem_reg_write, mem_mem_read,
              mem_mem_write, mem_branch_taken, exc_req, trap_busy, exc_epc};
        return x;
    endfunction

    task automatic check(string name, exp_t want);
        exp_t got;
        got = actual();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(in_t x);
        {stall, flush, ex_valid, ex_pc, alu_result, alu_zero, alu_overflow, ex_ovf_chk,
         ex_rt_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, exc_ack} = x;
    endtask

    task automatic run(vec_t x, string name);
        drive(x.i);
        sb.push_back(x.e);
        @(posedge clk);
        #1;
        check(name, sb.pop_front());
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t zero_e;
        zero_e = '0;
        rst_n = 1'b1;
        drive('0);
        #1 rst_n = 1'b0;
        #1 check("reset_state", zero_e);
        @(negedge clk);
        rst_n = 1'b1;

        // Each row is: inputs (s f v pc alu z o c rt rd rw mr mw br ack),
        // then expected outputs (v alu rt rd rw mr mw bt exc epc).
        tbl.push_back('{iv(0,0,1,0,32'h64,0,0,0,32'hAAAA,8,1,0,0,0,0),   e(1,32'h64,32'hAAAA,8,1,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,0,1,0,0,0,0,0,0,0,1,0),              e(1,0,0,0,0,0,0,1,0,0)});
        tbl.push_back('{iv(0,0,1,0,1,0,0,0,0,0,0,0,0,1,0),              e(1,1,0,0,0,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,0,0,32'h11,1,0,0,0,3,1,1,0,1,0),         e(0,32'h11,0,3,0,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,32'h1234,0,0,0,32'hBEEF,5,1,1,0,0,0), e(1,32'h1234,32'hBEEF,5,1,1,0,0,0,0)});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{iv(1,0,1,0,32'h5678,1,0,0,1,1,1,0,0,1,0),   e(1,32'h1234,32'hBEEF,5,1,1,0,0,0,0)});
        tbl.push_back('{iv(1,1,1,0,32'h9999,0,0,0,0,7,1,0,0,0,0),       e(0,32'h1234,32'hBEEF,5,0,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,32'h2000,0,0,0,32'hCAFE,0,0,0,1,0,0), e(1,32'h2000,32'hCAFE,0,0,0,1,0,0,0)});
        tbl.push_back('{iv(0,1,1,0,32'h3000,0,0,0,1,4,1,0,0,0,0),       e(0,32'h2000,32'hCAFE,0,0,0,0,0,0,0)});
        // Unsigned overflow loads normally; exc_ack in RUN is ignored.
        tbl.push_back('{iv(0,0,1,32'h0040_0010,32'h8000_0000,0,1,0,0,9,1,0,0,0,0), e(1,32'h8000_0000,0,9,1,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,7,0,0,0,0,2,1,0,0,0,1),              e(1,7,0,2,1,0,0,0,0,0)});
        // Signed overflow: trap entry, squashed follow-on load, second fault does not move epc.
        tbl.push_back('{iv(0,0,1,32'h0040_0010,32'h8000_0000,0,1,1,32'h33,10,1,0,0,0,0),
                        T ? e(0,32'h8000_0000,32'h33,10,0,0,0,0,1,EPC) : e(1,32'h8000_0000,32'h33,10,1,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,32'h55,0,0,0,32'h44,4,1,0,1,0,0),
                        T ? e(0,32'h55,32'h44,4,0,0,0,0,1,EPC) : e(1,32'h55,32'h44,4,1,0,1,0,0,0)});
        tbl.push_back('{iv(0,0,1,32'h100,32'h7FFF_FFFF,0,1,1,0,6,1,0,0,0,0),
                        T ? e(0,32'h7FFF_FFFF,0,6,0,0,0,0,1,EPC) : e(1,32'h7FFF_FFFF,0,6,1,0,0,0,0,0)});
        // ack during stall still leaves TRAP; the data path holds.
        tbl.push_back('{iv(1,0,1,0,32'h66,0,0,0,0,1,1,0,0,0,1),
                        T ? e(0,32'h7FFF_FFFF,0,6,0,0,0,0,0,EPC) : e(1,32'h7FFF_FFFF,0,6,1,0,0,0,0,0)});
        tbl.push_back('{iv(0,0,1,0,32'h77,0,0,0,32'h88,11,1,0,0,0,0),   e(1,32'h77,32'h88,11,1,0,0,0,0,EPC)});
        // fault with flush, then fault with stall: no capture either way.
        tbl.push_back('{iv(0,1,1,32'h200,32'h8000_0001,0,1,1,0,12,1,0,0,0,0), e(0,32'h77,32'h88,11,0,0,0,0,0,EPC)});
        tbl.push_back('{iv(1,0,1,32'h200,32'h8000_0001,0,1,1,0,12,1,0,0,0,0), e(0,32'h77,32'h88,11,0,0,0,0,0,EPC)});
        tbl.push_back('{iv(0,0,0,0,32'h99,0,0,0,0,13,0,0,0,0,0),        e(0,32'h99,0,13,0,0,0,0,0,EPC)});
        // Enter the trap again so that the reset below lands while in TRAP.
        tbl.push_back('{iv(0,0,1,32'h300,32'h8000_0000,0,1,1,0,14,1,0,0,0,0),
                        T ? e(0,32'h8000_0000,0,14,0,0,0,0,1,32'h300) : e(1,32'h8000_0000,0,14,1,0,0,0,0,0)});

        for (int i = 0; i < tbl.size(); i++)
            run(tbl[i], $sformatf("vec%0d", i));

        // Async reset between edges, asserted while in TRAP.
        #2 rst_n = 1'b0;
        #1 check("async_reset", zero_e);
        #2 rst_n = 1'b1;
        run('{iv(0,0,1,0,32'h42,0,0,0,0,15,1,0,0,0,0), e(1,32'h42,0,15,1,0,0,0,0,0)}, "post_reset_load");
        run('{iv(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0), e(0,0,0,0,0,0,0,0,0,0)}, "post_reset_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
